// File: rtl/mssd_pkg.sv
// Shared types and default geometry for the multichannel serial demux.
package mssd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        PAR,
        STOP,
        ERR
    } mssd_state_t;

    localparam int MSSD_CH_BITS  = 2;
    localparam int MSSD_LEN_BITS = 6;

endpackage

// File: rtl/mssd_bit_counter.sv
// Loadable down-counter with a zero flag; counts header bits and then data bits.
// Latency: load/decrement visible next cycle. No backpressure; stops at zero.
module mssd_bit_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mssd_param_demux.sv
// Serial frame demux: steers L data bits to one of 2**CH_BITS outputs, flags framing/parity faults.
// Latency: data bits appear on p in the same cycle they are sampled; pulses one cycle after stop.
// Backpressure: none, consumers must accept every valid bit.
module mssd_param_demux
    import mssd_pkg::*;
#(
    parameter int CH_BITS   = MSSD_CH_BITS,
    parameter int LEN_BITS  = MSSD_LEN_BITS,
    parameter int PARITY_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_in,
    output logic [CH_BITS-1:0]    pn,
    output logic                  out_valid,
    output logic [2**CH_BITS-1:0] p,
    output logic                  frame_done,
    output logic                  parity_err,
    output logic                  error
);

    localparam int NCH = 2**CH_BITS;
    localparam int HW  = CH_BITS + LEN_BITS;
    localparam int CW  = HW;

    mssd_state_t         state_q, state_d;
    logic [HW-2:0]       hdr_q, hdr_d;
    logic [CH_BITS-1:0]  pn_q, pn_d;
    logic                parity_q, parity_d;
    logic                frame_done_q, frame_done_d;
    logic                parity_err_q, parity_err_d;

    logic [HW-1:0]       hdr_full;
    logic [LEN_BITS-1:0] hdr_len;
    logic                cnt_load;
    logic [CW-1:0]       cnt_load_val;
    logic                cnt_dec;
    logic                cnt_zero;

    // The bit being sampled completes the header on its last cycle.
    assign hdr_full = {ser_in, hdr_q};
    assign hdr_len  = hdr_full[HW-1:CH_BITS];

    mssd_bit_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        pn_d         = pn_q;
        parity_d     = parity_q;
        frame_done_d = 1'b0;
        parity_err_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = CW'(HW - 1);
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ser_in) begin
                    state_d  = HDR;
                    parity_d = 1'b0;
                    cnt_load = 1'b1;
                end
            end
            HDR: begin
                hdr_d   = hdr_full[HW-1:1];
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    pn_d = hdr_full[CH_BITS-1:0];
                    if (hdr_len != '0) begin
                        state_d      = DATA;
                        cnt_load     = 1'b1;
                        cnt_load_val = CW'(hdr_len) - CW'(1);
                    end else begin
                        state_d = (PARITY_EN != 0) ? PAR : STOP;
                    end
                end
            end
            DATA: begin
                parity_d = parity_q ^ ser_in;
                cnt_dec  = 1'b1;
                if (cnt_zero) begin
                    state_d = (PARITY_EN != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                parity_d = parity_q ^ ser_in;
                state_d  = STOP;
            end
            STOP: begin
                // Without a parity bit there is nothing to check against.
                if (ser_in) begin
                    state_d = IDLE;
                    if ((PARITY_EN != 0) && parity_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end else begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (ser_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hdr_q        <= '0;
            pn_q         <= '0;
            parity_q     <= 1'b0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            pn_q         <= pn_d;
            parity_q     <= parity_d;
            frame_done_q <= frame_done_d;
            parity_err_q <= parity_err_d;
        end
    end

    always_comb begin
        p = '0;
        if (state_q == DATA) begin
            p[pn_q] = ser_in;
        end
    end

    assign pn         = pn_q;
    assign out_valid  = (state_q == DATA);
    assign frame_done = frame_done_q;
    assign parity_err = parity_err_q;
    assign error      = (state_q == ERR);

endmodule

// File: tb/tb_mssd_param_demux.sv
// Bench for mssd_param_demux: a 4-channel parity instance and an 8-channel no-parity instance.
module tb_mssd_param_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ser_a, ser_b;
    logic [1:0] pn_a;
    logic [3:0] p_a;
    logic       ov_a, fd_a, pe_a, err_a;
    logic [2:0] pn_b;
    logic [7:0] p_b;
    logic       ov_b, fd_b, pe_b, err_b;

    mssd_param_demux #(.CH_BITS(2), .LEN_BITS(6), .PARITY_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_a), .pn(pn_a), .out_valid(ov_a),
        .p(p_a), .frame_done(fd_a), .parity_err(pe_a), .error(err_a));

    mssd_param_demux #(.CH_BITS(3), .LEN_BITS(6), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_b), .pn(pn_b), .out_valid(ov_b),
        .p(p_b), .frame_done(fd_b), .parity_err(pe_b), .error(err_b));

    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_pn  [2];
    logic pend_fd [2];
    logic pend_pe [2];

    typedef struct {
        int          sel;
        int          ch;
        int          len;
        logic [62:0] data;
        logic        par;
        logic        stop;
        logic        fd;
        logic        pe;
        logic        err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic observe(input int sel, output logic [31:0] v, output logic [31:0] pv,
                           output logic [31:0] pnv, output logic [31:0] fd,
                           output logic [31:0] pe, output logic [31:0] er);
        if (sel == 1) begin
            v = 32'(ov_b); pv = 32'(p_b); pnv = 32'(pn_b);
            fd = 32'(fd_b); pe = 32'(pe_b); er = 32'(err_b);
        end else begin
            v = 32'(ov_a); pv = 32'(p_a); pnv = 32'(pn_a);
            fd = 32'(fd_a); pe = 32'(pe_a); er = 32'(err_a);
        end
    endtask

    task automatic drive(input int sel, input logic b);
        if (sel == 1) ser_b = b;
        else          ser_a = b;
    endtask

    task automatic idle(input int sel, input int n);
        logic [31:0] v, pv, pnv, fd, pe, er;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(sel, 1'b1);
            @(negedge clk);
            observe(sel, v, pv, pnv, fd, pe, er);
            chk("idle_valid", v, 0);
            chk("idle_p", pv, 0);
            chk("idle_pn", pnv, 32'(exp_pn[sel]));
            chk("idle_frame_done", fd, 32'(pend_fd[sel]));
            chk("idle_parity_err", pe, 32'(pend_pe[sel]));
            chk("idle_error", er, 0);
            pend_fd[sel] = 1'b0;
            pend_pe[sel] = 1'b0;
        end
    endtask

    // Builds the frame as a bit list and derives every expected output from bit positions.
    task automatic send_frame(input int sel, input int ch, input int len, input logic [62:0] data,
                              input logic par, input logic stop, input logic efd,
                              input logic epe, input logic eerr, input int abort_at);
        int   chb = (sel == 1) ? 3 : 2;
        int   par_en = (sel == 1) ? 0 : 1;
        int   hw = chb + 6;
        bit   q[$];
        logic dat;
        logic [31:0] v, pv, pnv, fd, pe, er;
        q.push_back(1'b0);
        for (int i = 0; i < chb; i++) q.push_back(ch[i]);
        for (int i = 0; i < 6; i++)   q.push_back(len[i]);
        for (int i = 0; i < len; i++) q.push_back(data[i]);
        if (par_en != 0) q.push_back(par);
        q.push_back(stop);
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk); #1;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                observe(sel, v, pv, pnv, fd, pe, er);
                chk("rst_valid", v, 0);
                chk("rst_p", pv, 0);
                chk("rst_pn", pnv, 0);
                chk("rst_frame_done", fd, 0);
                chk("rst_parity_err", pe, 0);
                chk("rst_error", er, 0);
                @(posedge clk);
                @(negedge clk);
                ser_a = 1'b1; ser_b = 1'b1;
                rst_n = 1'b1;
                exp_pn[0] = 0; exp_pn[1] = 0;
                pend_fd[0] = 0; pend_fd[1] = 0; pend_pe[0] = 0; pend_pe[1] = 0;
                return;
            end
            drive(sel, q[k]);
            @(negedge clk);
            observe(sel, v, pv, pnv, fd, pe, er);
            dat = (k >= 1 + hw) && (k < 1 + hw + len);
            chk("valid", v, 32'(dat));
            chk("p", pv, dat ? (32'(q[k]) << ch) : 32'd0);
            chk("pn", pnv, (k > hw) ? 32'(ch) : 32'(exp_pn[sel]));
            chk("frame_done", fd, (k == 0) ? 32'(pend_fd[sel]) : 32'd0);
            chk("parity_err", pe, (k == 0) ? 32'(pend_pe[sel]) : 32'd0);
            chk("error", er, 0);
            if (k == 0) begin
                pend_fd[sel] = 1'b0;
                pend_pe[sel] = 1'b0;
            end
        end
        exp_pn[sel] = ch;
        if (stop) begin
            pend_fd[sel] = efd;
            pend_pe[sel] = epe;
        end else begin
            for (int e = 0; e < 4; e++) begin
                @(posedge clk); #1;
                drive(sel, (e == 3));
                @(negedge clk);
                observe(sel, v, pv, pnv, fd, pe, er);
                chk("err_level", er, 32'(eerr));
                chk("err_valid", v, 0);
                chk("err_frame_done", fd, 0);
                chk("err_parity_err", pe, 0);
            end
        end
    endtask

    initial begin
        logic [31:0] v, pv, pnv, fd, pe, er;
        logic [63:0] rnd;
        rst_n = 1'b0;
        ser_a = 1'b1;
        ser_b = 1'b1;
        for (int s = 0; s < 2; s++) begin
            exp_pn[s] = 0; pend_fd[s] = 1'b0; pend_pe[s] = 1'b0;
        end

        tbl[0] = '{0, 2, 3, 63'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{0, 2, 3, 63'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{0, 1, 0, 63'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1, 2, 3, 63'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1, 1, 0, 63'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1, 6, 3, 63'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1, 7, 5, 63'h16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        #1;
        for (int s = 0; s < 2; s++) begin
            observe(s, v, pv, pnv, fd, pe, er);
            chk("reset_valid", v, 0);
            chk("reset_p", pv, 0);
            chk("reset_pn", pnv, 0);
            chk("reset_frame_done", fd, 0);
            chk("reset_parity_err", pe, 0);
            chk("reset_error", er, 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, 10);
        idle(1, 10);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].sel, tbl[i].ch, tbl[i].len, tbl[i].data, tbl[i].par,
                       tbl[i].stop, tbl[i].fd, tbl[i].pe, tbl[i].err, -1);
            idle(tbl[i].sel, 2);
        end

        // Back-to-back: the second start bit lands in the pulse cycle of the first frame.
        rnd = {$urandom, $urandom};
        send_frame(0, 3, 2, 63'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        send_frame(0, 0, 63, rnd[62:0], ^rnd[62:0], 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(0, 2);

        // Reset during the sixth data bit of an L=10 frame, then a clean frame.
        send_frame(0, 2, 10, 63'h3a5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1 + 8 + 5);
        idle(0, 2);
        send_frame(0, 1, 4, 63'h9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(0, 2);

        for (int r = 0; r < 40; r++) begin
            int   sel, chb, ch, len;
            logic pbit, parbit, stop, odd, efd, epe;
            sel  = $urandom_range(0, 1);
            chb  = (sel == 1) ? 3 : 2;
            ch   = $urandom_range(0, (1 << chb) - 1);
            len  = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 16);
            rnd  = {$urandom, $urandom};
            stop = ($urandom_range(0, 7) != 0);
            pbit = 1'b0;
            for (int i = 0; i < len; i++) pbit = pbit ^ rnd[i];
            parbit = pbit ^ ($urandom_range(0, 3) == 0);
            odd = (sel == 0) && (pbit ^ parbit);
            efd = stop && !odd;
            epe = stop && odd;
            send_frame(sel, ch, len, rnd[62:0], parbit, stop, efd, epe, !stop, -1);
            idle(sel, $urandom_range(1, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
